// File: rtl/dram_if_pkg.sv
// Purpose: shared DRAM user-port definitions (data/address widths, arbiter FSM encoding).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dram_if_pkg;

  // Defaults shared with the sample packer and the readback engine.
  localparam int MEM_IF_WIDTH = 128;
  localparam int ADX_WIDTH    = 27;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dram_rd_credit.sv
// Purpose: up/down saturating in-flight counter with full flag and sticky underflow error.
// Latency: count/err update on the edge after inc/dec; full is combinational from count.
// Backpressure: none; the owner must stop issuing inc while full.
// Ports: clk, resetn (sync, active-low); inc/dec strobes; count, full, err outputs.
module dram_rd_credit #(
  parameter int MAX_COUNT = 8,
  parameter int CNT_WIDTH = $clog2(MAX_COUNT + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 inc,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 full,
  output logic                 err
);

  localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(MAX_COUNT);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      // A return with nothing in flight is flagged; the count must not wrap.
      if (dec && (count == '0)) err <= 1'b1;
      // Simultaneous inc and dec cancel out.
      if (inc && !dec) begin
        if (count != MAX_C) count <= count + 1'b1;
      end else if (dec && !inc) begin
        if (count != '0) count <= count - 1'b1;
      end
    end
  end

  assign full = (count == MAX_C);

endmodule

// File: rtl/dram_port_arbiter.sv
// Purpose: shares the DRAM command port between capture writes (priority) and host reads.
// Latency: request sampled in IDLE -> command valid next cycle -> ack in first cycle with rdy.
// Backpressure: command held stable while mem_cmd_rdy=0; reads gated by in-flight credit.
// Ports: write req/adx/data/ack; read req/adx/ack; read return data/valid/outstanding/err;
//        memory command en/wr/adx/wdata/rdy; memory read return valid/data.
module dram_port_arbiter
  import dram_if_pkg::*;
#(
  parameter int MEM_IF_WIDTH    = dram_if_pkg::MEM_IF_WIDTH,
  parameter int ADX_WIDTH       = dram_if_pkg::ADX_WIDTH,
  parameter int STARVE_LIMIT    = 4,
  parameter int MAX_OUTSTANDING = 8,
  localparam int CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    wr_req,
  input  logic [ADX_WIDTH-1:0]    wr_adx,
  input  logic [MEM_IF_WIDTH-1:0] wr_data,
  output logic                    wr_ack,
  input  logic                    rd_req,
  input  logic [ADX_WIDTH-1:0]    rd_adx,
  output logic                    rd_ack,
  output logic                    rd_data_valid,
  output logic [MEM_IF_WIDTH-1:0] rd_data,
  output logic [CNT_WIDTH-1:0]    rd_outstanding,
  output logic                    rd_err,
  output logic                    mem_cmd_en,
  output logic                    mem_cmd_wr,
  output logic [ADX_WIDTH-1:0]    mem_adx,
  output logic [MEM_IF_WIDTH-1:0] mem_wdata,
  input  logic                    mem_cmd_rdy,
  input  logic                    mem_rd_valid,
  input  logic [MEM_IF_WIDTH-1:0] mem_rd_data
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e state_q, state_d;
  logic [SW-1:0] starve_q;
  logic          rd_full;
  logic          rd_elig;
  logic          grant_wr;
  logic          grant_rd;

  assign rd_elig = rd_req && !rd_full;

  always_comb begin
    state_d  = state_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    wr_ack   = 1'b0;
    rd_ack   = 1'b0;
    case (state_q)
      IDLE: begin
        // Writes win unless a pending read has been passed over STARVE_LIMIT times.
        if (wr_req && rd_elig && (starve_q == STARVE_MAX)) begin
          grant_rd = 1'b1;
          state_d  = RD;
        end else if (wr_req) begin
          grant_wr = 1'b1;
          state_d  = WR;
        end else if (rd_elig) begin
          grant_rd = 1'b1;
          state_d  = RD;
        end
      end
      WR: begin
        if (mem_cmd_rdy) begin
          wr_ack  = 1'b1;
          state_d = IDLE;
        end
      end
      RD: begin
        if (mem_cmd_rdy) begin
          rd_ack  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_cmd_en = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      starve_q      <= '0;
      mem_cmd_wr    <= 1'b0;
      mem_adx       <= '0;
      mem_wdata     <= '0;
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
    end else begin
      state_q <= state_d;

      if (!rd_req || grant_rd) begin
        starve_q <= '0;
      end else if (grant_wr && (starve_q != STARVE_MAX)) begin
        starve_q <= starve_q + 1'b1;
      end

      // Command is captured once at grant so it stays stable under backpressure.
      if (grant_wr) begin
        mem_cmd_wr <= 1'b1;
        mem_adx    <= wr_adx;
        mem_wdata  <= wr_data;
      end else if (grant_rd) begin
        mem_cmd_wr <= 1'b0;
        mem_adx    <= rd_adx;
      end

      rd_data_valid <= mem_rd_valid;
      if (mem_rd_valid) rd_data <= mem_rd_data;
    end
  end

  dram_rd_credit #(
    .MAX_COUNT (MAX_OUTSTANDING),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_rd_credit (
    .clk    (clk),
    .resetn (resetn),
    .inc    (rd_ack),
    .dec    (mem_rd_valid),
    .count  (rd_outstanding),
    .full   (rd_full),
    .err    (rd_err)
  );

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Purpose: self-checking bench for dram_port_arbiter (grant order, backpressure, credit, errors).
// Latency: n/a.
// Backpressure: mem_cmd_rdy driven by the bench per scenario.
module tb_dram_port_arbiter;

  localparam int AW = 27;
  localparam int DW = 128;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wr_req;
  logic [AW-1:0] wr_adx;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          rd_req;
  logic [AW-1:0] rd_adx;
  logic          rd_ack;
  logic          rd_data_valid;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] rd_outstanding;
  logic          rd_err;
  logic          mem_cmd_en;
  logic          mem_cmd_wr;
  logic [AW-1:0] mem_adx;
  logic [DW-1:0] mem_wdata;
  logic          mem_cmd_rdy;
  logic          mem_rd_valid;
  logic [DW-1:0] mem_rd_data;

  always #5 clk = ~clk;

  dram_port_arbiter #(
    .MEM_IF_WIDTH    (DW),
    .ADX_WIDTH       (AW),
    .STARVE_LIMIT    (4),
    .MAX_OUTSTANDING (8)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .wr_req         (wr_req),
    .wr_adx         (wr_adx),
    .wr_data        (wr_data),
    .wr_ack         (wr_ack),
    .rd_req         (rd_req),
    .rd_adx         (rd_adx),
    .rd_ack         (rd_ack),
    .rd_data_valid  (rd_data_valid),
    .rd_data        (rd_data),
    .rd_outstanding (rd_outstanding),
    .rd_err         (rd_err),
    .mem_cmd_en     (mem_cmd_en),
    .mem_cmd_wr     (mem_cmd_wr),
    .mem_adx        (mem_adx),
    .mem_wdata      (mem_wdata),
    .mem_cmd_rdy    (mem_cmd_rdy),
    .mem_rd_valid   (mem_rd_valid),
    .mem_rd_data    (mem_rd_data)
  );

  int errors = 0;
  int checks = 0;

  bit            grant_q[$];  // expected grant order, 1 = write
  logic [DW-1:0] rdata_q[$];  // expected returned read data

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    wr_req       = 1'b0;
    wr_adx       = '0;
    wr_data      = '0;
    rd_req       = 1'b0;
    rd_adx       = '0;
    mem_cmd_rdy  = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_inputs();
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic check_rd_return(input string name);
    logic [DW-1:0] exp;
    checks++;
    if (rdata_q.size() == 0) begin
      errors++;
      $display("FAIL %s: read data returned with nothing expected", name);
    end else begin
      exp = rdata_q.pop_front();
      if (rd_data_valid !== 1'b1 || rd_data !== exp) begin
        errors++;
        $display("FAIL %s: valid=%0b data=%h, required valid=1 data=%h", name, rd_data_valid, rd_data, exp);
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_inputs();
    wr_req = 1'b1;
    mem_cmd_rdy = 1'b1;
    step();
    step();
    checks++;
    if (mem_cmd_en !== 1'b0 || wr_ack !== 1'b0 || rd_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_cmd: en=%0b wr_ack=%0b rd_ack=%0b, required 0", mem_cmd_en, wr_ack, rd_ack);
    end
    checks++;
    if (mem_cmd_wr !== 1'b0 || mem_adx !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_cmd_regs: wr=%0b adx=%h wdata=%h, required 0", mem_cmd_wr, mem_adx, mem_wdata);
    end
    checks++;
    if (rd_data_valid !== 1'b0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_rdata: valid=%0b data=%h, required 0", rd_data_valid, rd_data);
    end
    checks++;
    if (rd_outstanding !== 4'd0 || rd_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_credit: outstanding=%0d err=%0b, required 0", rd_outstanding, rd_err);
    end
    wr_req = 1'b0;
    resetn = 1'b1;
  endtask

  task automatic test_write_only();
    logic [DW-1:0] d;
    d = 128'hA5A5_0001_DEAD_BEEF_0123_4567_89AB_CDEF;
    do_reset();
    wr_req = 1'b1;
    wr_adx = 27'h10;
    wr_data = d;
    mem_cmd_rdy = 1'b1;
    step();
    checks++;
    if (mem_cmd_en !== 1'b1 || mem_cmd_wr !== 1'b1 || mem_adx !== 27'h10 || mem_wdata !== d) begin
      errors++;
      $display("FAIL wr_cmd: en=%0b wr=%0b adx=%h wdata=%h, required 1 1 10 %h", mem_cmd_en, mem_cmd_wr, mem_adx, mem_wdata, d);
    end
    checks++;
    if (wr_ack !== 1'b1 || rd_ack !== 1'b0) begin
      errors++;
      $display("FAIL wr_ack: wr_ack=%0b rd_ack=%0b, required 1 0", wr_ack, rd_ack);
    end
    wr_req = 1'b0;
    step();
    checks++;
    if (mem_cmd_en !== 1'b0 || wr_ack !== 1'b0) begin
      errors++;
      $display("FAIL wr_idle: en=%0b wr_ack=%0b, required 0 0", mem_cmd_en, wr_ack);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d;
    d = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    do_reset();
    wr_req = 1'b1;
    wr_adx = 27'h33;
    wr_data = d;
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_cmd_en !== 1'b1 || mem_adx !== 27'h33 || mem_wdata !== d || wr_ack !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: en=%0b adx=%h wdata=%h ack=%0b, required 1 33 %h 0", i, mem_cmd_en, mem_adx, mem_wdata, wr_ack, d);
      end
      step();
    end
    mem_cmd_rdy = 1'b1;
    #1;
    checks++;
    if (wr_ack !== 1'b1) begin
      errors++;
      $display("FAIL bp_ack: wr_ack=%0b, required 1", wr_ack);
    end
    wr_req = 1'b0;
    step();
    checks++;
    if (mem_cmd_en !== 1'b0 || wr_ack !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: en=%0b ack=%0b, required 0 0", mem_cmd_en, wr_ack);
    end
  endtask

  task automatic test_starvation();
    bit exp;
    int n;
    do_reset();
    grant_q = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    wr_req = 1'b1;
    wr_adx = 27'h100;
    rd_req = 1'b1;
    rd_adx = 27'h200;
    mem_cmd_rdy = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 60 && grant_q.size() > 0; cyc++) begin
      step();
      if (wr_ack || rd_ack) begin
        exp = grant_q.pop_front();
        checks++;
        if ((wr_ack && !rd_ack) !== exp) begin
          errors++;
          $display("FAIL starve_grant[%0d]: wr_ack=%0b rd_ack=%0b, required write=%0b", n, wr_ack, rd_ack, exp);
        end
        n++;
        if (grant_q.size() == 0) begin
          wr_req = 1'b0;
          rd_req = 1'b0;
        end
      end
    end
    checks++;
    if (grant_q.size() != 0) begin
      errors++;
      $display("FAIL starve_timeout: %0d grants missing, required 0", grant_q.size());
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    step();
  endtask

  task automatic test_credit_limit();
    int  n;
    bit  seen;
    logic [DW-1:0] d;
    d = 128'hC0FF_EE00_0000_0000_0000_0000_0000_0009;
    do_reset();
    rd_req = 1'b1;
    rd_adx = 27'h40;
    mem_cmd_rdy = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
      step();
      if (rd_ack) n++;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL credit_fill: reads accepted=%0d, required 8", n);
    end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      seen |= rd_ack;
    end
    checks++;
    if (seen !== 1'b0 || rd_outstanding !== 4'd8) begin
      errors++;
      $display("FAIL credit_block: rd_ack_seen=%0b outstanding=%0d, required 0 8", seen, rd_outstanding);
    end
    wr_req = 1'b1;
    wr_adx = 27'h55;
    step();
    checks++;
    if (wr_ack !== 1'b1 || mem_cmd_wr !== 1'b1 || mem_adx !== 27'h55) begin
      errors++;
      $display("FAIL credit_write: ack=%0b wr=%0b adx=%h, required 1 1 55", wr_ack, mem_cmd_wr, mem_adx);
    end
    wr_req = 1'b0;
    step();
    mem_rd_valid = 1'b1;
    mem_rd_data = d;
    rdata_q.push_back(d);
    step();
    mem_rd_valid = 1'b0;
    check_rd_return("credit_return");
    checks++;
    if (rd_outstanding !== 4'd7 || rd_ack !== 1'b0) begin
      errors++;
      $display("FAIL credit_dec: outstanding=%0d rd_ack=%0b, required 7 0", rd_outstanding, rd_ack);
    end
    step();
    checks++;
    if (rd_ack !== 1'b1 || mem_cmd_wr !== 1'b0) begin
      errors++;
      $display("FAIL credit_9th: rd_ack=%0b wr=%0b, required 1 0", rd_ack, mem_cmd_wr);
    end
    rd_req = 1'b0;
    step();
    checks++;
    if (rd_outstanding !== 4'd8) begin
      errors++;
      $display("FAIL credit_refill: outstanding=%0d, required 8", rd_outstanding);
    end
  endtask

  task automatic test_simul_accept_return();
    logic [DW-1:0] d;
    d = 128'hFACE_0000_1234_0000_5678_0000_9ABC_0005;
    do_reset();
    rd_req = 1'b1;
    rd_adx = 27'h20;
    mem_cmd_rdy = 1'b1;
    step();
    checks++;
    if (rd_ack !== 1'b1 || mem_cmd_wr !== 1'b0 || mem_adx !== 27'h20) begin
      errors++;
      $display("FAIL simul_rd1: ack=%0b wr=%0b adx=%h, required 1 0 20", rd_ack, mem_cmd_wr, mem_adx);
    end
    rd_adx = 27'h21;
    step();
    checks++;
    if (rd_outstanding !== 4'd1) begin
      errors++;
      $display("FAIL simul_cnt1: outstanding=%0d, required 1", rd_outstanding);
    end
    step();
    checks++;
    if (rd_ack !== 1'b1 || mem_adx !== 27'h21) begin
      errors++;
      $display("FAIL simul_rd2: ack=%0b adx=%h, required 1 21", rd_ack, mem_adx);
    end
    mem_rd_valid = 1'b1;
    mem_rd_data = d;
    rdata_q.push_back(d);
    rd_req = 1'b0;
    #1;
    checks++;
    if (rd_data_valid !== 1'b0) begin
      errors++;
      $display("FAIL simul_early: rd_data_valid=%0b, required 0", rd_data_valid);
    end
    step();
    mem_rd_valid = 1'b0;
    mem_rd_data = '0;
    check_rd_return("simul_return");
    checks++;
    if (rd_outstanding !== 4'd1) begin
      errors++;
      $display("FAIL simul_cnt: outstanding=%0d, required 1", rd_outstanding);
    end
    step();
    checks++;
    if (rd_data_valid !== 1'b0 || rd_data !== d) begin
      errors++;
      $display("FAIL simul_hold: valid=%0b data=%h, required 0 %h", rd_data_valid, rd_data, d);
    end
  endtask

  task automatic test_error_reset();
    logic [DW-1:0] d;
    d = 128'hBAD0_0000_0000_0000_0000_0000_0000_0BAD;
    do_reset();
    mem_rd_valid = 1'b1;
    mem_rd_data = d;
    rdata_q.push_back(d);
    step();
    mem_rd_valid = 1'b0;
    check_rd_return("err_forward");
    checks++;
    if (rd_err !== 1'b1 || rd_outstanding !== 4'd0) begin
      errors++;
      $display("FAIL err_set: err=%0b outstanding=%0d, required 1 0", rd_err, rd_outstanding);
    end
    step();
    step();
    checks++;
    if (rd_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%0b, required 1", rd_err);
    end
    wr_req = 1'b1;
    wr_adx = 27'h77;
    step();
    checks++;
    if (mem_cmd_en !== 1'b1 || mem_cmd_wr !== 1'b1) begin
      errors++;
      $display("FAIL err_wr_pending: en=%0b wr=%0b, required 1 1", mem_cmd_en, mem_cmd_wr);
    end
    resetn = 1'b0;
    step();
    checks++;
    if (mem_cmd_en !== 1'b0 || rd_err !== 1'b0 || wr_ack !== 1'b0 || rd_outstanding !== 4'd0) begin
      errors++;
      $display("FAIL err_midreset: en=%0b err=%0b ack=%0b outstanding=%0d, required 0 0 0 0", mem_cmd_en, rd_err, wr_ack, rd_outstanding);
    end
    resetn = 1'b1;
    mem_cmd_rdy = 1'b1;
    step();
    checks++;
    if (wr_ack !== 1'b1 || mem_adx !== 27'h77) begin
      errors++;
      $display("FAIL err_reissue: ack=%0b adx=%h, required 1 77", wr_ack, mem_adx);
    end
    wr_req = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_write_only();
    test_backpressure();
    test_starvation();
    test_credit_limit();
    test_simul_accept_return();
    test_error_reset();
    checks++;
    if (rdata_q.size() != 0) begin
      errors++;
      $display("FAIL rdata_leftover: %0d entries never returned, required 0", rdata_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
